// File: rtl/bster_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bster_pkg
// Description : Shared definitions for the bster completion collector:
//               the "status OK" code, the status code enumeration and the
//               packed response layout {status, completion} at the default
//               widths (8-bit status, 128-bit completion).
// Revision    : 1.0 - initial release
// ============================================================================
package bster_pkg;

    localparam int BSTER_STS_WIDTH = 8;
    localparam int BSTER_CMD_WIDTH = 128;

    // Any status other than STS_OK marks the response as an error.
    localparam logic [BSTER_STS_WIDTH-1:0] STS_OK = '0;

    typedef enum logic [BSTER_STS_WIDTH-1:0] {
        STS_SUCCESS    = 8'h00,
        STS_DECODE_ERR = 8'h01,
        STS_SLAVE_ERR  = 8'h02,
        STS_TIMEOUT    = 8'h03,
        STS_ABORT      = 8'h04
    } bster_sts_e;

    // Merged response beat: status in the MSBs, completion payload below.
    typedef struct packed {
        logic [BSTER_STS_WIDTH-1:0] sts;
        logic [BSTER_CMD_WIDTH-1:0] cpl;
    } bster_rsp_t;

endpackage : bster_pkg
`default_nettype wire

// File: rtl/bster_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bster_sync_fifo
// Description : Single-clock FIFO with registered full flag. DEPTH must be a
//               power of two so the pointers wrap naturally.
// Ports       : clk_i    - clock
//               rst_ni   - synchronous active-low reset
//               push_i   - write wdata_i (ignored while full)
//               pop_i    - drop the head entry (ignored while empty)
//               wdata_i  - write data
//               rdata_o  - head entry
//               full_o   - registered full flag (held high during reset)
//               empty_o  - occupancy is zero
// Revision    : 1.0 - initial release
// ============================================================================
module bster_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             push_w;
    logic             pop_w;

    assign push_w = push_i && !full_q;
    assign pop_w  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_w && !pop_w) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_w && pop_w) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // The full flag is computed from next-state occupancy so the upstream
    // ready it drives is registered yet never lets a beat overflow. It stays
    // high in reset so no beat is accepted until the cycle after release.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule : bster_sync_fifo
`default_nettype wire

// File: rtl/bster_cpl_collector.sv
`default_nettype none
// ============================================================================
// Module      : bster_cpl_collector
// Description : Buffers the bster core's completion and status streams in
//               two independent FIFOs, pairs their heads in arrival order
//               into a one-entry output register and keeps saturating
//               response / error counters.
//               Optional desync watchdog: define BSTER_CPL_TIMEOUT_EN.
// Ports       : aclk, aresetn         - clock, synchronous active-low reset
//               cpl_tvalid/tready/tdata - completion stream from the core
//               sts_tvalid/tready/tdata - status stream from the core
//               rsp_tvalid/tready/tdata - merged {sts, cpl} stream to host
//               clr                   - clears counters and desync flag
//               rsp_count, err_count  - saturating delivery/error counters
//               desync                - sticky watchdog flag (0 if disabled)
// Revision    : 1.0 - initial release
// ============================================================================
module bster_cpl_collector
    import bster_pkg::*;
#(
    parameter int CMD_WIDTH      = 128,
    parameter int STS_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cpl_tvalid,
    output logic                          cpl_tready,
    input  logic [CMD_WIDTH-1:0]          cpl_tdata,
    input  logic                          sts_tvalid,
    output logic                          sts_tready,
    input  logic [STS_WIDTH-1:0]          sts_tdata,
    output logic                          rsp_tvalid,
    input  logic                          rsp_tready,
    output logic [STS_WIDTH+CMD_WIDTH-1:0] rsp_tdata,
    input  logic                          clr,
    output logic [CNT_WIDTH-1:0]          rsp_count,
    output logic [CNT_WIDTH-1:0]          err_count,
    output logic                          desync
);

    localparam int RSP_W = STS_WIDTH + CMD_WIDTH;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("bster_cpl_collector: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    logic                 cpl_full_w, cpl_empty_w;
    logic                 sts_full_w, sts_empty_w;
    logic [CMD_WIDTH-1:0] cpl_head_w;
    logic [STS_WIDTH-1:0] sts_head_w;
    logic                 load_w;
    logic                 hs_w;
    logic                 hs_err_w;

    logic                 rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]     rsp_data_q,  rsp_data_d;
    logic [CNT_WIDTH-1:0] rsp_cnt_q,   rsp_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q,   err_cnt_d;

    assign cpl_tready = !cpl_full_w;
    assign sts_tready = !sts_full_w;

    bster_sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_cpl_fifo (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (cpl_tvalid && cpl_tready),
        .pop_i   (load_w),
        .wdata_i (cpl_tdata),
        .rdata_o (cpl_head_w),
        .full_o  (cpl_full_w),
        .empty_o (cpl_empty_w)
    );

    bster_sync_fifo #(
        .WIDTH (STS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_sts_fifo (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (sts_tvalid && sts_tready),
        .pop_i   (load_w),
        .wdata_i (sts_tdata),
        .rdata_o (sts_head_w),
        .full_o  (sts_full_w),
        .empty_o (sts_empty_w)
    );

    // Both heads leave together, so the two streams can never reorder.
    assign load_w   = !cpl_empty_w && !sts_empty_w && (!rsp_valid_q || rsp_tready);
    assign hs_w     = rsp_valid_q && rsp_tready;
    assign hs_err_w = hs_w && (rsp_data_q[RSP_W-1 -: STS_WIDTH] != STS_WIDTH'(STS_OK));

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (load_w) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = {sts_head_w, cpl_head_w};
        end else if (hs_w) begin
            rsp_valid_d = 1'b0;
        end
    end

    // clr wins over a same-cycle handshake; counters stick at all-ones.
    always_comb begin
        rsp_cnt_d = rsp_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            rsp_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            if (hs_w && rsp_cnt_q != '1) begin
                rsp_cnt_d = rsp_cnt_q + CNT_WIDTH'(1);
            end
            if (hs_err_w && err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cnt_q   <= rsp_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rsp_tvalid = rsp_valid_q;
    assign rsp_tdata  = rsp_data_q;
    assign rsp_count  = rsp_cnt_q;
    assign err_count  = err_cnt_q;

`ifdef BSTER_CPL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            desync_q, desync_d;
    logic            lone_w;

    // Exactly one side holds data: the other stream is lagging.
    assign lone_w = cpl_empty_w ^ sts_empty_w;

    always_comb begin
        wd_cnt_d = '0;
        if (lone_w) begin
            wd_cnt_d = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES)) ? wd_cnt_q
                                                           : wd_cnt_q + WD_W'(1);
        end
        desync_d = clr ? 1'b0 : (desync_q || (wd_cnt_d == WD_W'(TIMEOUT_CYCLES)));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wd_cnt_q <= '0;
            desync_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            desync_q <= desync_d;
        end
    end

    assign desync = desync_q;
`else
    assign desync = 1'b0;
`endif

endmodule : bster_cpl_collector
`default_nettype wire
